adq_seq: RTL and testbench

//  Parametrised multi-channel acquisition sequencer: scans a masked set of ADC channels
//  for a programmed number of sweeps, or continuously. Per conversion: start pulse, wait
//  for end-of-conversion with timeout, capture the sample. Samples leave on a

---
 rtl/adq_seq.sv | 199 +++++++++++++++++++
 tb/tb_adq_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adq_seq.sv
// adq_seq: scans a masked set of ADC channels for a number of sweeps (or forever),
// one start/eoc/capture per channel, and hands each sample out on a valid/ready stream.
module adq_seq #(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 12,
   parameter int N_SAMP_W = 8,
   parameter int TIMEOUT  = 255,
   localparam int CH_W    = $clog2(N_CH),
   localparam int TMR_W   = $clog2(TIMEOUT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init,
   input  logic                abort,
   input  logic [N_CH-1:0]     ch_mask,
   input  logic [N_SAMP_W-1:0] n_samp,
   output logic                adc_start,
   output logic [CH_W-1:0]     adc_ch,
   input  logic                eoc,
   input  logic [DATA_W-1:0]   adc_data,
   output logic                smp_valid,
   input  logic                smp_ready,
   output logic [DATA_W-1:0]   smp_data,
   output logic [CH_W-1:0]     smp_ch,
   output logic                smp_last,
   output logic                busy,
   output logic                done,
   output logic                err_timeout,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_STORE = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [N_SAMP_W-1:0] sweep_q, sweep_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [N_CH-1:0]     mask_q, mask_d;
   logic [N_SAMP_W-1:0] nsamp_q, nsamp_d;
   logic                vld_q, vld_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CH_W-1:0]     sch_q, sch_d;
   logic                last_q, last_d;

   logic [CH_W-1:0]     lo_in, lo_ch, hi_ch, up_ch;
   logic                up_found;
   logic [N_SAMP_W-1:0] sweep_inc;
   logic                last_sweep;
   logic                init_go;

   // Channel search over the masks: lowest enabled (new request and latched mask),
   // highest enabled, and the nearest enabled channel above the current one.
   always_comb begin
      lo_in    = '0;
      lo_ch    = '0;
      hi_ch    = '0;
      up_ch    = '0;
      up_found = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) lo_in = CH_W'(i);
         if (mask_q[i]) lo_ch = CH_W'(i);
         if (mask_q[i] && (CH_W'(i) > ch_q)) begin
            up_ch    = CH_W'(i);
            up_found = 1'b1;
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (mask_q[i]) hi_ch = CH_W'(i);
      end
   end

   assign sweep_inc  = sweep_q + N_SAMP_W'(1);
   assign last_sweep = (nsamp_q != '0) && (sweep_inc == nsamp_q);
   assign init_go    = init && (ch_mask != '0) && !abort;

   // Sample stream: smp_valid rises with a captured sample and, once high, data/ch/last
   // stay frozen until the cycle smp_ready is seen high; the word transfers on that edge.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      sweep_d = sweep_q;
      timer_d = timer_q;
      mask_d  = mask_q;
      nsamp_d = nsamp_q;
      vld_d   = vld_q;
      data_d  = data_q;
      sch_d   = sch_q;
      last_d  = last_q;

      case (state_q)
         S_INIT: begin
            mask_d  = ch_mask;
            nsamp_d = n_samp;
            ch_d    = lo_in;
            sweep_d = '0;
            state_d = S_START;
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // eoc wins over the timeout on the final wait cycle
            if (eoc) begin
               data_d  = adc_data;
               sch_d   = ch_q;
               last_d  = (ch_q == hi_ch) && last_sweep;
               vld_d   = 1'b1;
               state_d = S_STORE;
            end else if (timer_q == TMR_W'(TIMEOUT)) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_STORE: begin
            if (smp_ready) begin
               vld_d   = 1'b0;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (up_found) begin
               ch_d    = up_ch;
               state_d = S_START;
            end else begin
               ch_d    = lo_ch;
               sweep_d = sweep_inc;
               state_d = last_sweep ? S_DONE : S_START;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      // Restart or abort discards any in-flight sample without emitting it.
      if (init_go) begin
         state_d = S_INIT;
         vld_d   = 1'b0;
         data_d  = data_q;
         sch_d   = sch_q;
         last_d  = last_q;
      end else if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         vld_d   = 1'b0;
         data_d  = data_q;
         sch_d   = sch_q;
         last_d  = last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         sweep_q <= '0;
         timer_q <= '0;
         mask_q  <= '0;
         nsamp_q <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         sch_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         sweep_q <= sweep_d;
         timer_q <= timer_d;
         mask_q  <= mask_d;
         nsamp_q <= nsamp_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         sch_q   <= sch_d;
         last_q  <= last_d;
      end
   end

   assign adc_start   = (state_q == S_START);
   assign adc_ch      = ch_q;
   assign smp_valid   = vld_q;
   assign smp_data    = data_q;
   assign smp_ch      = sch_q;
   assign smp_last    = last_q;
   assign busy        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign done        = (state_q == S_DONE);
   assign err_timeout = (state_q == S_ERR);
   assign state       = state_q;

endmodule

// File: tb/tb_adq_seq.sv
// tb_adq_seq: control-vector table, scan scenarios, corner sequences and random scans
// of adq_seq, with expected samples derived from a sweep-plan model.
module tb_adq_seq;
   localparam int N_CH     = 4;
   localparam int DATA_W   = 12;
   localparam int N_SAMP_W = 8;
   localparam int TIMEOUT  = 255;
   localparam int CH_W     = 2;
   localparam int SW       = 1 + CH_W + DATA_W;

   logic                clk = 1'b0;
   logic                rst, init, abort, eoc, smp_ready;
   logic [N_CH-1:0]     ch_mask;
   logic [N_SAMP_W-1:0] n_samp;
   logic [DATA_W-1:0]   adc_data;
   logic                adc_start, smp_valid, smp_last, busy, done, err_timeout;
   logic [CH_W-1:0]     adc_ch, smp_ch;
   logic [DATA_W-1:0]   smp_data;
   logic [2:0]          state;

   adq_seq #(
      .N_CH(N_CH), .DATA_W(DATA_W), .N_SAMP_W(N_SAMP_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .init(init), .abort(abort), .ch_mask(ch_mask),
      .n_samp(n_samp), .adc_start(adc_start), .adc_ch(adc_ch), .eoc(eoc),
      .adc_data(adc_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
      .smp_data(smp_data), .smp_ch(smp_ch), .smp_last(smp_last), .busy(busy),
      .done(done), .err_timeout(err_timeout), .state(state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [SW-1:0] exp_q[$];
   int exp_ch[$];
   bit exp_last[$];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference plan: enabled channels in ascending order, one pass per sweep;
   // the last entry of a finite run carries the last flag.
   task automatic build_plan(input logic [N_CH-1:0] mask, input int nsamp, input int limit);
      exp_ch.delete();
      exp_last.delete();
      if (mask == '0) return;
      if (nsamp == 0) begin
         while (exp_ch.size() < limit)
            for (int c = 0; c < N_CH; c++)
               if (mask[c] && exp_ch.size() < limit) begin
                  exp_ch.push_back(c);
                  exp_last.push_back(1'b0);
               end
      end else begin
         for (int s = 0; s < nsamp; s++)
            for (int c = 0; c < N_CH; c++)
               if (mask[c]) begin
                  exp_ch.push_back(c);
                  exp_last.push_back(1'b0);
               end
         exp_last[exp_last.size() - 1] = 1'b1;
         if (limit > 0)
            while (exp_ch.size() > limit) begin
               void'(exp_ch.pop_back());
               void'(exp_last.pop_back());
            end
      end
   endtask

   task automatic run_scan(input logic [N_CH-1:0] mask, input int nsamp, input int limit,
                           input int dlo, input int dhi, input int slo, input int shi,
                           input bit do_init, input string tag);
      int dly, stall;
      logic [DATA_W-1:0] d;
      logic [SW-1:0] exp;
      build_plan(mask, nsamp, limit);
      ch_mask   = mask;
      n_samp    = N_SAMP_W'(nsamp);
      smp_ready = 1'b0;
      if (do_init) begin
         init = 1'b1;
         step();
         init = 1'b0;
         check({tag, " init->INIT"}, state, 3'd1);
         step();
      end
      for (int i = 0; i < exp_ch.size(); i++) begin
         check($sformatf("%s s%0d adc_start", tag, i), adc_start, 1'b1);
         check($sformatf("%s s%0d adc_ch", tag, i), adc_ch, exp_ch[i]);
         check($sformatf("%s s%0d busy", tag, i), busy, 1'b1);
         dly = $urandom_range(dhi, dlo);
         step();
         repeat (dly - 1) step();
         eoc      = 1'b1;
         d        = DATA_W'($urandom);
         adc_data = d;
         exp_q.push_back({exp_last[i], CH_W'(exp_ch[i]), d});
         step();
         eoc      = 1'b0;
         adc_data = DATA_W'($urandom);
         check($sformatf("%s s%0d valid", tag, i), smp_valid, 1'b1);
         exp   = exp_q[0];
         stall = $urandom_range(shi, slo);
         repeat (stall) begin
            step();
            check($sformatf("%s s%0d hold", tag, i), {smp_valid, smp_last, smp_ch, smp_data},
                  {1'b1, exp});
            check($sformatf("%s s%0d no start in STORE", tag, i), adc_start, 1'b0);
         end
         exp = exp_q.pop_front();
         check($sformatf("%s s%0d sample", tag, i), {smp_last, smp_ch, smp_data}, exp);
         smp_ready = 1'b1;
         step();
         smp_ready = 1'b0;
         check($sformatf("%s s%0d valid drop", tag, i), smp_valid, 1'b0);
         step();
      end
      if (limit == 0) begin
         check({tag, " done"}, done, 1'b1);
         check({tag, " busy after done"}, busy, 1'b0);
         check({tag, " no start after done"}, adc_start, 1'b0);
         check({tag, " state DONE"}, state, 3'd6);
      end
   endtask

   typedef struct {
      logic       init, abort, eoc;
      logic [3:0] mask;
      logic [2:0] exp_state;
      logic       exp_busy, exp_start, exp_valid;
   } vec_t;
   vec_t vecs[12];

   typedef struct {
      logic [3:0] mask;
      int         nsamp, dlo, dhi, slo, shi;
   } scn_t;
   scn_t scns[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_CH-1:0] rmask;
      int rn;

      // init abort eoc mask -> state busy start valid
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'b0011, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0011, 3'd3, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'b0011, 3'd4, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0011, 3'd4, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 3'd4, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0, 1'b0};

      scns[0] = '{4'b1011, 2, 3, 3, 0, 0};
      scns[1] = '{4'b0001, 1, 256, 256, 0, 0};
      scns[2] = '{4'b1000, 3, 1, 1, 10, 10};
      scns[3] = '{4'b1111, 1, 1, 4, 0, 3};
      scns[4] = '{4'b0110, 2, 2, 5, 1, 2};

      rst = 1'b1; init = 1'b0; abort = 1'b0; eoc = 1'b0;
      ch_mask = '0; n_samp = '0; adc_data = '0; smp_ready = 1'b0;
      repeat (3) step();
      check("reset outputs",
            {adc_start, adc_ch, smp_valid, smp_data, smp_ch, smp_last, busy, done,
             err_timeout, state}, 32'd0);
      rst = 1'b0;

      n_samp   = 8'd1;
      adc_data = 12'h5A5;
      for (int i = 0; i < 12; i++) begin
         init    = vecs[i].init;
         abort   = vecs[i].abort;
         eoc     = vecs[i].eoc;
         ch_mask = vecs[i].mask;
         step();
         check($sformatf("vec%0d state", i), state, vecs[i].exp_state);
         check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
         check($sformatf("vec%0d adc_start", i), adc_start, vecs[i].exp_start);
         check($sformatf("vec%0d smp_valid", i), smp_valid, vecs[i].exp_valid);
      end
      init = 1'b0; abort = 1'b0; eoc = 1'b0;

      for (int i = 0; i < 5; i++)
         run_scan(scns[i].mask, scns[i].nsamp, 0, scns[i].dlo, scns[i].dhi,
                  scns[i].slo, scns[i].shi, 1'b1, $sformatf("scn%0d", i));

      // continuous single channel, then abort
      run_scan(4'b0100, 0, 20, 1, 3, 0, 1, 1'b1, "cont");
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("cont abort state", state, 3'd0);
      check("cont abort busy", busy, 1'b0);

      // eoc timeout, then restart clears the error
      ch_mask = 4'b0001; n_samp = 8'd1;
      init = 1'b1;
      step();
      init = 1'b0;
      step();
      step();
      check("tmo WAIT entry", state, 3'd3);
      repeat (255) step();
      check("tmo still waiting", {err_timeout, state}, {1'b0, 3'd3});
      step();
      check("tmo err", err_timeout, 1'b1);
      check("tmo state ERR", state, 3'd7);
      check("tmo busy", busy, 1'b0);
      init = 1'b1;
      step();
      init = 1'b0;
      check("tmo reinit state", state, 3'd1);
      check("tmo reinit err", err_timeout, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("tmo abort", state, 3'd0);

      // restart mid-run: sweep count restarts and eoc during INIT is dropped
      run_scan(4'b0011, 2, 2, 1, 3, 0, 2, 1'b1, "rst_a");
      step();
      check("midinit in WAIT", state, 3'd3);
      init = 1'b1;
      step();
      init = 1'b0;
      check("midinit INIT", state, 3'd1);
      eoc = 1'b1; adc_data = 12'hFFF;
      step();
      eoc = 1'b0;
      check("midinit START", state, 3'd2);
      check("midinit no capture", smp_valid, 1'b0);
      run_scan(4'b0011, 2, 0, 1, 3, 0, 2, 1'b0, "rst_b");

      // synchronous reset with a sample pending
      ch_mask = 4'b0010; n_samp = 8'd1;
      init = 1'b1;
      step();
      init = 1'b0;
      step();
      step();
      eoc = 1'b1; adc_data = 12'hABC;
      step();
      eoc = 1'b0;
      check("rst6 pending sample", {smp_valid, smp_ch, smp_data}, {1'b1, 2'd1, 12'hABC});
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst6 outputs cleared",
            {adc_start, adc_ch, smp_valid, smp_data, smp_ch, smp_last, busy, done,
             err_timeout, state}, 32'd0);
      ch_mask = 4'b0000;
      init = 1'b1;
      step();
      init = 1'b0;
      check("rst6 init mask0 stays IDLE", state, 3'd0);

      for (int r = 0; r < 8; r++) begin
         rmask = N_CH'($urandom_range(15, 1));
         rn    = $urandom_range(3, 0);
         if (rn == 0) begin
            run_scan(rmask, 0, $urandom_range(9, 3), 1, 8, 0, 4, 1'b1, $sformatf("rnd%0d", r));
            abort = 1'b1;
            step();
            abort = 1'b0;
            check($sformatf("rnd%0d abort", r), state, 3'd0);
         end else begin
            run_scan(rmask, rn, 0, 1, 8, 0, 4, 1'b1, $sformatf("rnd%0d", r));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
